seq_div: RTL
============

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a, input, WIDTH bits: dividend; sampled with start.
REQ-007 SHALL have port b, input, WIDTH bits: divisor; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking q, r and dbz valid.
REQ-010 SHALL have port q, output, WIDTH bits: quotient.
REQ-011 SHALL have port r, output, WIDTH bits: remainder.
REQ-012 SHALL have port dbz, output, 1 bit: divide-by-zero flag for the result in q and r.

Function
REQ-013 SHALL use a state machine with states IDLE, RUN, FIX and DONE.
REQ-014 IDLE with start=1 SHALL register the operands and is_signed; next state RUN, or DONE if b==0.
REQ-015 In signed mode, operands SHALL be converted to magnitudes on acceptance.
- Record sign_q = a[MSB]^b[MSB].
- Record sign_r = a[MSB].
REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly WIDTH cycles, counted by a down-counter from WIDTH-1.
REQ-017 After the final RUN step the next state SHALL be FIX.
- FIX negates the quotient if sign_q and the remainder if sign_r (signed mode only).
- FIX loads q and r.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be WIDTH+2 cycles from the start-accepting edge to the done-asserting edge (34 for WIDTH=32); a start in the DONE-return cycle is accepted the next cycle in IDLE.
REQ-020 Signed results SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-021 Signed INT_MIN / -1 SHALL give q = INT_MIN and r = 0, with no flag.
REQ-022 Divide by zero SHALL give q = all ones, r = a and dbz = 1, with done asserted on the edge after acceptance (latency 1).
- dbz = 0 for every other result.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the operation in progress or its result.
REQ-024 q, r and dbz SHALL hold their values from done until the next result is loaded.
REQ-025 Operand inputs SHALL NOT be required to stay stable after the accepting edge.

Reset
REQ-026 rst_n low SHALL immediately force the following, regardless of clk:
- state = IDLE;
- busy = 0, done = 0;
- q = 0, r = 0, dbz = 0;
- counter and internal registers cleared.
REQ-027 Reset mid-operation SHALL abandon the operation with no done pulse.
- The first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package/include SHALL hold:
- the state encoding constants (IDLE, RUN, FIX, DONE);
- the default WIDTH.
REQ-029 One combinational sub-module div_step SHALL implement a single restoring step.
- Inputs: partial remainder, next dividend bit, divisor.
- Outputs: new partial remainder, quotient bit.
REQ-030 Sign handling, counter and FSM SHALL reside in seq_div.

Verification
REQ-031 Unsigned: a=100, b=7 -> q=14, r=2, dbz=0; done exactly 34 cycles after start, busy high throughout.
REQ-032 Signed truncation, each pair checked independently:
- -7/2 -> q=-3, r=-1;
- 7/-2 -> q=-3, r=1;
- -7/-2 -> q=3, r=-1.
REQ-033 Divide by zero: a=0x12345678, b=0 -> q=0xFFFFFFFF, r=0x12345678, dbz=1, done one cycle after start.
REQ-034 Signed overflow: a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0; unsigned a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0.
REQ-035 Reset and busy handling:
- Pulse rst_n low at RUN cycle 10 -> outputs 0, no done; subsequent 5/6 -> q=0, r=5.
- start with new operands during RUN -> ignored, original result returned.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider: state encoding and default width.
package seq_div_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring shift-subtract step. The partial remainder is always below
// the divisor, so the shifted value fits in WIDTH+1 bits and the borrow out
// of the subtraction decides the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] shf;
  logic [WIDTH:0] diff;

  assign shf  = {rem, dbit};
  assign diff = shf - {1'b0, dvs};

  // Keep the difference when no borrow, otherwise restore the shifted value.
  always_comb begin
    qbit    = ~diff[WIDTH];
    rem_nxt = diff[WIDTH] ? shf[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per cycle.
// The dividend register doubles as the quotient register: its MSB feeds the
// step each cycle while the new quotient bit shifts in at the LSB.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, rem, dvs;
  logic             sgn_q, sgn_r;
  logic [WIDTH-1:0] rem_nxt;
  logic             qbit;
  logic             bzero;
  logic             a_neg, b_neg;

  assign bzero = (b == '0);
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dbit    (dvd[WIDTH-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state and busy decode; a zero divisor skips straight to DONE.
  always_comb begin
    nxt  = state;
    busy = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = bzero ? DONE : RUN;
      end
      RUN:     if (cnt == '0) nxt = FIX;
      FIX:     nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: capture magnitudes on accept, iterate, apply signs, pulse done
  // on the edge leaving DONE so the result is registered one cycle before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dvd   <= '0;
      rem   <= '0;
      dvs   <= '0;
      sgn_q <= 1'b0;
      sgn_r <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt   <= CW'(WIDTH - 1);
          rem   <= '0;
          dvd   <= a_neg ? -a : a;
          dvs   <= b_neg ? -b : b;
          sgn_q <= a_neg ^ b_neg;
          sgn_r <= a_neg;
          if (bzero) begin
            q   <= '1;
            r   <= a;
            dbz <= 1'b1;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          dvd <= {dvd[WIDTH-2:0], qbit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          q   <= sgn_q ? -dvd : dvd;
          r   <= sgn_r ? -rem : rem;
          dbz <= 1'b0;
        end
        DONE:    done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
